// File: rtl/auto_con_pkg.sv
// -----------------------------------------------------------------------------
// auto_con_pkg
// Shared definitions for the engine coolant/oil fault indicator (auto_con).
//   - status_t     : status encoding driven on the status port (3 never used)
//   - RGB_*        : indicator colour constants, bit order {R,G,B}
//   - IDX_*        : bit positions of the four sensors in the fault vectors,
//                    vector order {ol,ot,cl,ct}
//   - classify()   : debounced fault vector -> status
//   - status_rgb() : steady indicator colour for a status
// -----------------------------------------------------------------------------
package auto_con_pkg;

    typedef enum logic [1:0] {
        STAT_OK   = 2'd0,
        STAT_WARN = 2'd1,
        STAT_CRIT = 2'd2
    } status_t;

    localparam logic [2:0] RGB_GREEN  = 3'b010;
    localparam logic [2:0] RGB_YELLOW = 3'b110;
    localparam logic [2:0] RGB_RED    = 3'b100;
    localparam logic [2:0] RGB_OFF    = 3'b000;

    localparam int NUM_SENSORS = 4;
    localparam int IDX_CT = 0;
    localparam int IDX_CL = 1;
    localparam int IDX_OT = 2;
    localparam int IDX_OL = 3;

    // Any over-temperature is critical; losing both coolant and oil level
    // together is critical; losing exactly one level is only a warning.
    function automatic status_t classify(input logic [NUM_SENSORS-1:0] faults);
        logic temp_fault;
        logic level_any;
        logic level_both;
        temp_fault = faults[IDX_CT] | faults[IDX_OT];
        level_any  = faults[IDX_CL] | faults[IDX_OL];
        level_both = faults[IDX_CL] & faults[IDX_OL];
        if (temp_fault || level_both) begin
            return STAT_CRIT;
        end else if (level_any) begin
            return STAT_WARN;
        end else begin
            return STAT_OK;
        end
    endfunction

    function automatic logic [2:0] status_rgb(input status_t s);
        case (s)
            STAT_WARN: return RGB_YELLOW;
            STAT_CRIT: return RGB_RED;
            default:   return RGB_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/auto_con_if.sv
// -----------------------------------------------------------------------------
// auto_con_if
// Signal bundle between the sensor/host side and auto_con.
//   ct, cl, ot, ol  : raw fault inputs (asynchronous to clk), active-high
//   clr_sticky      : single-cycle synchronous request to clear sticky flags
//   rgb[2:0]        : indicator LED {R,G,B}
//   status[1:0]     : 0=OK, 1=WARN, 2=CRIT
//   fault_sticky[3:0]: latched faults, order {ol,ot,cl,ct}
// Modports: master drives the sensors and clear request, slave is auto_con.
// -----------------------------------------------------------------------------
interface auto_con_if;

    logic       ct;
    logic       cl;
    logic       ot;
    logic       ol;
    logic       clr_sticky;
    logic [2:0] rgb;
    logic [1:0] status;
    logic [3:0] fault_sticky;

    modport master (
        output ct, cl, ot, ol, clr_sticky,
        input  rgb, status, fault_sticky
    );

    modport slave (
        input  ct, cl, ot, ol, clr_sticky,
        output rgb, status, fault_sticky
    );

endinterface

// File: rtl/auto_con_debounce.sv
// -----------------------------------------------------------------------------
// auto_con_debounce
// Two-flop synchronizer followed by a consecutive-cycle debounce filter for a
// single asynchronous level input.
//   Parameter DEBOUNCE_CYCLES (1..255): synchronized cycles a new level must be
//   held before it is accepted.
//   Ports: clk, rst_n (async, active-low), din (raw async input),
//          dout (debounced level, registered).
// A new level sampled on edge 1 reaches dout on edge DEBOUNCE_CYCLES+2.
// -----------------------------------------------------------------------------
module auto_con_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    // The flip happens on the cycle the count would reach DEBOUNCE_CYCLES, so
    // compare against one less than that.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       deb_reg;
    logic       deb_next;
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            deb_reg   <= deb_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Counter clears on any match and on acceptance, so only an unbroken run
    // of differing samples can flip the output.
    always_comb begin
        deb_next = deb_reg;
        cnt_next = '0;
        if (sync2_reg != deb_reg) begin
            if (cnt_reg == CNT_LAST) begin
                deb_next = ~deb_reg;
            end else begin
                cnt_next = cnt_reg + 8'd1;
            end
        end
    end

    assign dout = deb_reg;

endmodule

// File: rtl/auto_con.sv
// -----------------------------------------------------------------------------
// auto_con
// Engine coolant/oil fault indicator. Four asynchronous fault inputs are
// synchronized and debounced, classified into OK/WARN/CRIT, shown on an RGB
// indicator, and latched into sticky flags that a host can clear.
//   Parameters: DEBOUNCE_CYCLES (1..255), BLINK_HALF_PERIOD (1..65535)
//   Ports: clk, rst_n (async, active-low),
//          bus (auto_con_if.slave): ct, cl, ot, ol, clr_sticky in;
//                                   rgb, status, fault_sticky out (registered)
//   Build option: define AUTO_CON_BLINK_EN to blink red in CRIT
//   (BLINK_HALF_PERIOD cycles on, BLINK_HALF_PERIOD off, restarting red-on at
//   every CRIT entry). Without it CRIT shows steady red.
// -----------------------------------------------------------------------------
module auto_con
    import auto_con_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int BLINK_HALF_PERIOD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    auto_con_if.slave   bus
);

    logic [NUM_SENSORS-1:0] raw;
    logic [NUM_SENSORS-1:0] deb;

    assign raw = {bus.ol, bus.ot, bus.cl, bus.ct};

    generate
        for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
            auto_con_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (raw[gi]),
                .dout (deb[gi])
            );
        end
    endgenerate

    status_t                status_reg;
    status_t                status_next;
    logic [2:0]             rgb_reg;
    logic [2:0]             rgb_next;
    logic [NUM_SENSORS-1:0] sticky_reg;
    logic [NUM_SENSORS-1:0] sticky_next;

    // A clear only drops bits whose debounced fault is already gone: OR-ing
    // the live faults back in makes set win over a simultaneous clear.
    always_comb begin
        status_next = classify(deb);
        sticky_next = deb | (bus.clr_sticky ? '0 : sticky_reg);
    end

`ifdef AUTO_CON_BLINK_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF_PERIOD - 1);

    logic [15:0] blink_cnt_reg;
    logic [15:0] blink_cnt_next;
    logic        blink_off_reg;
    logic        blink_off_next;

    // Counter and phase stay at zero/red-on unless CRIT continues from the
    // previous cycle, so every CRIT entry starts with a full red phase.
    always_comb begin
        blink_cnt_next = '0;
        blink_off_next = 1'b0;
        rgb_next       = status_rgb(status_next);
        if (status_next == STAT_CRIT && status_reg == STAT_CRIT) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_off_next = ~blink_off_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 16'd1;
                blink_off_next = blink_off_reg;
            end
            if (blink_off_next) begin
                rgb_next = RGB_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            blink_off_reg <= blink_off_next;
        end
    end
`else
    always_comb begin
        rgb_next = status_rgb(status_next);
    end
`endif

    // status and rgb come from the same debounced vector and load on the same
    // edge, so the indicator and the status code never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_reg <= STAT_OK;
            rgb_reg    <= RGB_GREEN;
            sticky_reg <= '0;
        end else begin
            status_reg <= status_next;
            rgb_reg    <= rgb_next;
            sticky_reg <= sticky_next;
        end
    end

    assign bus.rgb          = rgb_reg;
    assign bus.status       = status_reg;
    assign bus.fault_sticky = sticky_reg;

endmodule

// File: tb/tb_auto_con.sv
// -----------------------------------------------------------------------------
// tb_auto_con
// Self-checking bench for auto_con (DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=8).
// A reference model derives the debounced levels from the input history
// (a level is accepted once the synchronized samples of the last
// DEBOUNCE_CYCLES edges all disagree with it), then classifies, latches sticky
// flags and computes the blink phase from the cycles elapsed since CRIT entry.
// Honours AUTO_CON_BLINK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_auto_con;
    import auto_con_pkg::*;

    localparam int D = 4;
    localparam int H = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    auto_con_if bus_if ();

    auto_con #(
        .DEBOUNCE_CYCLES  (D),
        .BLINK_HALF_PERIOD(H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         n_edge;
    logic [3:0] hist[$];
    logic [3:0] m_deb;
    int         last_flip[4];
    int         prev_status;
    int         crit_entry;
    int         exp_status;
    int         exp_rgb;
    int         exp_sticky;

    function automatic logic [3:0] raw_at(input int m);
        if (m < 1) return 4'b0000;
        return hist[m-1];
    endfunction

    function automatic int ref_classify(input logic [3:0] f);
        int temp;
        int levels;
        temp   = (f[0] || f[2]) ? 1 : 0;
        levels = int'(f[1]) + int'(f[3]);
        if (temp == 1 || levels == 2) return 2;
        if (levels == 1) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        n_edge = 0;
        hist.delete();
        m_deb = 4'b0000;
        for (int i = 0; i < 4; i++) last_flip[i] = 0;
        prev_status = 0;
        crit_entry  = 0;
        exp_status  = 0;
        exp_rgb     = 3'b010;
        exp_sticky  = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic clr);
        int st;
        logic flip;
        logic [3:0] seen;
        n_edge++;
        hist.push_back(raw);
        st = ref_classify(m_deb);
        if (st == 2 && prev_status != 2) crit_entry = n_edge;
        exp_status = st;
        exp_sticky = int'(m_deb) | (clr ? 0 : exp_sticky);
        if (st == 2) begin
`ifdef AUTO_CON_BLINK_EN
            exp_rgb = (((n_edge - crit_entry) / H) % 2 == 0) ? 3'b100 : 3'b000;
`else
            exp_rgb = 3'b100;
`endif
        end else if (st == 1) begin
            exp_rgb = 3'b110;
        end else begin
            exp_rgb = 3'b010;
        end
        prev_status = st;
        // The filter at edge j looks at the input sampled two edges earlier.
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = n_edge - D + 1; j <= n_edge; j++) begin
                seen = raw_at(j - 2);
                if (j <= last_flip[i] || seen[i] == m_deb[i]) flip = 1'b0;
            end
            if (flip) begin
                m_deb[i]     = ~m_deb[i];
                last_flip[i] = n_edge;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 time unit later.
    task automatic tick(input logic [3:0] s, input logic clr);
        {bus_if.ol, bus_if.ot, bus_if.cl, bus_if.ct} = s;
        bus_if.clr_sticky = clr;
        @(posedge clk);
        model_edge(s, clr);
        #1;
        chk("rgb",          int'(bus_if.rgb),          exp_rgb);
        chk("status",       int'(bus_if.status),       exp_status);
        chk("fault_sticky", int'(bus_if.fault_sticky), exp_sticky);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rgb"},    int'(bus_if.rgb),          3'b010);
        chk({tag, "_status"}, int'(bus_if.status),       0);
        chk({tag, "_sticky"}, int'(bus_if.fault_sticky), 0);
    endtask

    logic [3:0] cur;
    logic       clr_r;

    initial begin
        {bus_if.ol, bus_if.ot, bus_if.cl, bus_if.ct} = 4'b0000;
        bus_if.clr_sticky = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        #3 rst_n = 1'b1;
        $display("txn reset: released");

        repeat (10) tick(4'b0000, 1'b0);
        $display("txn idle: all sensors low");

        // Sweep every fault combination.
        for (int v = 0; v < 16; v++) begin
            repeat (20) tick(4'(v), 1'b0);
            chk("sweep_class", int'(bus_if.status), ref_classify(4'(v)));
            $display("txn sweep: {ol,ot,cl,ct}=%b status=%0d rgb=%b", 4'(v), bus_if.status, bus_if.rgb);
        end
        repeat (20) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        repeat (3) tick(4'b0000, 1'b0);
        $display("txn clear after sweep: sticky=%b", bus_if.fault_sticky);

        // Short glitch must be ignored.
        repeat (3) tick(4'b0001, 1'b0);
        repeat (20) tick(4'b0000, 1'b0);
        chk("glitch_rgb",    int'(bus_if.rgb),          3'b010);
        chk("glitch_sticky", int'(bus_if.fault_sticky), 0);
        $display("txn ct glitch 3 cycles: rgb=%b", bus_if.rgb);

        // Held ct reaches red on the 7th edge.
        for (int i = 1; i <= 10; i++) begin
            tick(4'b0001, 1'b0);
            chk("ct_latency", (bus_if.rgb == 3'b100) ? 1 : 0, (i >= 7) ? 1 : 0);
        end
        $display("txn ct held: rgb=%b", bus_if.rgb);
        repeat (20) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        repeat (2) tick(4'b0000, 1'b0);

        // Sticky ol: held after the pulse, cleared by request.
        repeat (10) tick(4'b1000, 1'b0);
        repeat (15) tick(4'b0000, 1'b0);
        chk("ol_sticky_held", int'(bus_if.fault_sticky), 4'b1000);
        tick(4'b0000, 1'b1);
        chk("ol_sticky_clr", int'(bus_if.fault_sticky), 4'b0000);
        $display("txn ol pulse + clear: sticky=%b", bus_if.fault_sticky);
        repeat (10) tick(4'b1000, 1'b0);
        tick(4'b1000, 1'b1);
        chk("ol_set_wins", int'(bus_if.fault_sticky[3]), 1);
        $display("txn clear with ol high: sticky=%b", bus_if.fault_sticky);
        repeat (20) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);

        // Held ot: blink or steady red depending on build.
        repeat (40) tick(4'b0100, 1'b0);
        $display("txn ot held 40 cycles: rgb=%b", bus_if.rgb);
        repeat (20) tick(4'b0000, 1'b0);

        // Random sensor activity with occasional clear requests.
        cur = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 6) == 0) cur[b] = ~cur[b];
            end
            clr_r = ($urandom_range(0, 7) == 0);
            tick(cur, clr_r);
        end
        $display("txn random: 400 cycles done, sensors=%b", cur);
        repeat (20) tick(4'b0000, 1'b1);

        // Reset during CRIT, then re-detection with normal latency.
        repeat (15) tick(4'b0100, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_values("async_rst");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("in_rst");
        #3 rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(4'b0100, 1'b0);
            chk("redetect", (bus_if.status == 2'd2) ? 1 : 0, (i >= 7) ? 1 : 0);
        end
        $display("txn reset mid-CRIT: status=%0d rgb=%b", bus_if.status, bus_if.rgb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/auto_con.md
AUTO_CON -- requirements
Module: auto_con

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles a sensor must hold a new level before acceptance (legal 1..255).
REQ-002 Parameter BLINK_HALF_PERIOD, default 8, clock cycles per red on/off phase when blinking (legal 1..65535).
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port ct  input  1  coolant temperature high fault, active-high, asynchronous to clk.
REQ-006 Port cl  input  1  coolant level low fault, active-high, asynchronous.
REQ-007 Port ot  input  1  oil temperature high fault, active-high, asynchronous.
REQ-008 Port ol  input  1  oil level low fault, active-high, asynchronous.
REQ-009 Port clr_sticky  input  1  synchronous single-cycle request to clear sticky flags.
REQ-010 Port rgb  output  3  indicator LED {R,G,B}, registered.
REQ-011 Port status  output  2  0=OK, 1=WARN, 2=CRIT; 3 never driven; registered.
REQ-012 Port fault_sticky  output  4  latched faults, bit order {ol,ot,cl,ct}; registered.

Function
REQ-013 Each sensor SHALL pass a 2-flop synchronizer, then a debounce filter.
REQ-014 Debounce: counter increments each cycle the synchronized value differs from the debounced value; clears whenever they match; debounced value flips and counter clears when count reaches DEBOUNCE_CYCLES.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change any output.
REQ-016 Latency: a stable input change SHALL appear on rgb/status at the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the new level.
REQ-017 Classification from debounced faults: CRIT if ct or ot, or cl and ol both; WARN if exactly one of cl/ol with no temperature fault; otherwise OK.
REQ-018 Colour: OK -> rgb 3'b010 (green); WARN -> 3'b110 (yellow); CRIT -> 3'b100 (red), subject to REQ-024.
REQ-019 fault_sticky[i] SHALL set on the cycle debounced fault i is 1 and hold until cleared.
REQ-020 clr_sticky high SHALL clear all sticky bits whose debounced fault is 0; simultaneous set and clear -> set wins.
REQ-021 status and rgb SHALL update in the same cycle; no combinational input-to-output path.

Reset
REQ-022 While rst_n low: synchronizers, debounced values, counters, fault_sticky = 0; status = 0; rgb = 3'b010.
REQ-023 Reset asserted mid-debounce or mid-blink SHALL discard the count; after release, operation resumes from the reset state on the next edge.

Configuration
REQ-024 Macro AUTO_CON_BLINK_EN defined: in CRIT, red SHALL be on for BLINK_HALF_PERIOD cycles, then rgb 3'b000 for BLINK_HALF_PERIOD cycles, repeating; phase restarts red-on at each CRIT entry; blink counter held at 0 outside CRIT.
REQ-025 Macro not defined: CRIT drives steady 3'b100; no blink counter is synthesized.

Structure
REQ-026 Package auto_con_pkg SHALL hold the status encoding (STAT_OK/WARN/CRIT) and colour constants (RGB_GREEN, RGB_YELLOW, RGB_RED, RGB_OFF).
REQ-027 Sub-module auto_con_debounce (synchronizer + debounce for one bit, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times; classification, sticky and blink logic stay in auto_con.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=8)
REQ-028 Reset, all sensors 0 -> rgb 3'b010, status 0, fault_sticky 4'b0000.
REQ-029 Sweep {ol,ot,cl,ct} 0..15, each held 20 cycles -> 1 and 2 give CRIT/WARN as per REQ-017; e.g. 4'b0010 -> 3'b110 status 1; 4'b1010 -> CRIT; 4'b0001 -> CRIT.
REQ-030 ct high for 3 cycles, then low -> rgb stays 3'b010, fault_sticky stays 0; ct high held -> rgb 3'b100 on the 7th edge.
REQ-031 ol pulsed 10 cycles, then low, then clr_sticky -> fault_sticky 4'b1000 until clear, 0 after; clr_sticky with ol still high -> bit 3 stays 1.
REQ-032 With AUTO_CON_BLINK_EN, ot held high -> rgb alternates 3'b100 and 3'b000 every 8 cycles; without it -> steady 3'b100.
REQ-033 rst_n pulsed low during CRIT -> outputs immediately take reset values; faults re-detected after the REQ-016 latency.
